cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 118 +++++++++++
 tb/tb_cdb_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Requester/CDB bundle for cdb_arbiter: functional-unit result requests in,
// registered common-data-bus lanes out.
interface cdb_arbiter_if #(
   parameter int N       = 2,
   parameter int NUM_REQ = 4,
   parameter int T_W     = 6,
   parameter int D_W     = 32
);
   // Handshake: a result moves from requester i in any cycle where
   // req_valid[i] && req_ready[i]; req_ready never depends on req_ready or cdb_*.
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0][T_W-1:0] req_t;
   logic [NUM_REQ-1:0][D_W-1:0] req_data;
   logic [NUM_REQ-1:0]          req_taken;
   logic                        br_en;
   logic [NUM_REQ-1:0]          req_ready;
   logic [N-1:0]                cdb_valid;
   logic [N-1:0][T_W-1:0]       cdb_t;
   logic [N-1:0][D_W-1:0]       cdb_data;
   logic                        cdb_taken;

   modport master (
      output req_valid, req_t, req_data, req_taken, br_en,
      input  req_ready, cdb_valid, cdb_t, cdb_data, cdb_taken
   );

   modport slave (
      input  req_valid, req_t, req_data, req_taken, br_en,
      output req_ready, cdb_valid, cdb_t, cdb_data, cdb_taken
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to N of NUM_REQ requesters per cycle onto
// registered lanes. Define CDB_BR_PRIO_EN to pin the branch requester to lane 0.
module cdb_arbiter #(
   parameter int N       = 2,
   parameter int NUM_REQ = 4,
   parameter int BR_REQ  = 0,
   parameter int T_W     = 6,
   parameter int D_W     = 32,
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic             clock,
   input  logic             reset,
   cdb_arbiter_if.slave     bus,
   output logic [PTR_W-1:0] o_rr_ptr
);

`ifdef CDB_BR_PRIO_EN
   localparam bit BR_PRIO = 1'b1;
`else
   localparam bit BR_PRIO = 1'b0;
`endif

   logic [PTR_W-1:0]          r_rr_ptr;
   logic [PTR_W-1:0]          w_rr_next;
   logic [PTR_W-1:0]          w_rr_adv;
   logic                      w_rr_any;
   logic [NUM_REQ-1:0]        w_grant;
   logic [N-1:0]              w_lane_valid;
   logic [N-1:0][T_W-1:0]     w_lane_t;
   logic [N-1:0][D_W-1:0]     w_lane_data;
   logic                      w_lane_taken;
   logic [N-1:0]              r_cdb_valid;
   logic [N-1:0][T_W-1:0]     r_cdb_t;
   logic [N-1:0][D_W-1:0]     r_cdb_data;
   logic                      r_cdb_taken;

   // State register: round-robin pointer
   always_ff @(posedge clock) begin
      if (reset) r_rr_ptr <= '0;
      else       r_rr_ptr <= w_rr_next;
   end

   // Next-state: squash freezes the pointer; a branch-priority grant never moves it
   always_comb begin
      w_rr_next = r_rr_ptr;
      if (!bus.br_en && w_rr_any) w_rr_next = w_rr_adv;
   end

   // Output logic: scan from r_rr_ptr, k-th grant fills lane k
   always_comb begin
      int               cnt;
      int               pos;
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] last;
      cnt          = 0;
      pos          = 0;
      idx          = '0;
      last         = r_rr_ptr;
      w_grant      = '0;
      w_lane_valid = '0;
      w_lane_t     = '0;
      w_lane_data  = '0;
      w_lane_taken = 1'b0;
      w_rr_any     = 1'b0;
      if (BR_PRIO && bus.req_valid[BR_REQ]) begin
         w_grant[BR_REQ] = 1'b1;
         w_lane_valid[0] = 1'b1;
         w_lane_t[0]     = bus.req_t[BR_REQ];
         w_lane_data[0]  = bus.req_data[BR_REQ];
         w_lane_taken    = bus.req_taken[BR_REQ];
         cnt             = 1;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         pos = int'(r_rr_ptr) + j;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         idx = PTR_W'(pos);
         if (bus.req_valid[idx] && (cnt < N) && !(BR_PRIO && (pos == BR_REQ))) begin
            for (int k = 0; k < N; k++) begin
               if (cnt == k) begin
                  w_lane_valid[k] = 1'b1;
                  w_lane_t[k]     = bus.req_t[idx];
                  w_lane_data[k]  = bus.req_data[idx];
                  if (k == 0) w_lane_taken = bus.req_taken[idx];
               end
            end
            w_grant[idx] = 1'b1;
            cnt          = cnt + 1;
            last         = idx;
            w_rr_any     = 1'b1;
         end
      end
      w_rr_adv = (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
   end

   assign bus.req_ready = w_grant & {NUM_REQ{~reset & ~bus.br_en}};

   // Lanes already carry zeros when invalid, so a plain register suffices
   always_ff @(posedge clock) begin
      if (reset || bus.br_en) begin
         r_cdb_valid <= '0;
         r_cdb_t     <= '0;
         r_cdb_data  <= '0;
         r_cdb_taken <= 1'b0;
      end else begin
         r_cdb_valid <= w_lane_valid;
         r_cdb_t     <= w_lane_t;
         r_cdb_data  <= w_lane_data;
         r_cdb_taken <= w_lane_taken;
      end
   end

   assign bus.cdb_valid = r_cdb_valid;
   assign bus.cdb_t     = r_cdb_t;
   assign bus.cdb_data  = r_cdb_data;
   assign bus.cdb_taken = r_cdb_taken;
   assign o_rr_ptr      = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter (N=2, NUM_REQ=4, BR_REQ=0); expectations
// follow CDB_BR_PRIO_EN when the bench is compiled with that macro.
module tb_cdb_arbiter;
   localparam int N       = 2;
   localparam int NUM_REQ = 4;
   localparam int T_W     = 6;
   localparam int D_W     = 16;
`ifdef CDB_BR_PRIO_EN
   localparam int WAIT_BOUND = 3;
`else
   localparam int WAIT_BOUND = 2;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] rr_ptr;
   int         n_total = 0;
   int         n_pass  = 0;

   always #5 clock = ~clock;

   cdb_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ), .T_W(T_W), .D_W(D_W)) bus ();

   cdb_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .BR_REQ(0), .T_W(T_W), .D_W(D_W)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .o_rr_ptr (rr_ptr)
   );

   typedef struct {
      logic        rst;
      logic        br;
      logic [3:0]  v;
      logic [23:0] t;
      logic [63:0] d;
      logic [3:0]  tk;
      logic [3:0]  rdy;
      logic [1:0]  cv;
      logic [11:0] ct;
      logic [31:0] cd;
      logic        ctk;
      logic [1:0]  rr;
   } vec_t;

   localparam logic [23:0] T_STD = {6'd4, 6'd3, 6'd2, 6'd1};
   localparam logic [63:0] D_STD = {16'h0404, 16'h0303, 16'h0202, 16'h0101};

   vec_t vecs[12];

   function automatic vec_t mk(input logic rst, input logic br, input logic [3:0] v,
                               input logic [23:0] t, input logic [63:0] d, input logic [3:0] tk,
                               input logic [3:0] rdy, input logic [1:0] cv, input logic [11:0] ct,
                               input logic [31:0] cd, input logic ctk, input logic [1:0] rr);
      vec_t r;
      r.rst = rst; r.br = br; r.v = v; r.t = t; r.d = d; r.tk = tk;
      r.rdy = rdy; r.cv = cv; r.ct = ct; r.cd = cd; r.ctk = ctk; r.rr = rr;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
   endtask

   task automatic drive(input vec_t x);
      reset          = x.rst;
      bus.br_en      = x.br;
      bus.req_valid  = x.v;
      bus.req_t      = x.t;
      bus.req_data   = x.d;
      bus.req_taken  = x.tk;
   endtask

   initial begin
      int wait_cnt[NUM_REQ];
      logic [3:0] rdy;

      vecs[0]  = mk(1, 0, 4'b1111, T_STD, D_STD, 4'b0001, 4'b0000, 2'b00, 12'h0, 32'h0, 0, 2'd0);
      vecs[1]  = mk(0, 0, 4'b1111, T_STD, D_STD, 4'b0001, 4'b0011, 2'b11, {6'd2, 6'd1},
                    {16'h0202, 16'h0101}, 1, 2'd2);
`ifdef CDB_BR_PRIO_EN
      vecs[2]  = mk(0, 0, 4'b1111, T_STD, D_STD, 4'b0001, 4'b0101, 2'b11, {6'd3, 6'd1},
                    {16'h0303, 16'h0101}, 1, 2'd3);
`else
      vecs[2]  = mk(0, 0, 4'b1111, T_STD, D_STD, 4'b0001, 4'b1100, 2'b11, {6'd4, 6'd3},
                    {16'h0404, 16'h0303}, 0, 2'd0);
`endif
      vecs[3]  = mk(0, 0, 4'b1000, {6'd9, 18'd0}, {16'h0055, 48'h0}, 4'b1000, 4'b1000, 2'b01,
                    {6'd0, 6'd9}, {16'h0000, 16'h0055}, 1, 2'd0);
      vecs[4]  = mk(0, 0, 4'b0010, {12'd0, 6'd7, 6'd0}, {32'h0, 16'h0777, 16'h0}, 4'b0000, 4'b0010,
                    2'b01, {6'd0, 6'd7}, {16'h0000, 16'h0777}, 0, 2'd2);
      vecs[5]  = mk(0, 1, 4'b1011, T_STD, D_STD, 4'b0001, 4'b0000, 2'b00, 12'h0, 32'h0, 0, 2'd2);
      vecs[6]  = mk(0, 0, 4'b0000, T_STD, D_STD, 4'b0000, 4'b0000, 2'b00, 12'h0, 32'h0, 0, 2'd2);
`ifdef CDB_BR_PRIO_EN
      vecs[7]  = mk(0, 0, 4'b1001, T_STD, D_STD, 4'b1001, 4'b1001, 2'b11, {6'd4, 6'd1},
                    {16'h0404, 16'h0101}, 1, 2'd0);
      vecs[8]  = mk(0, 0, 4'b0111, T_STD, D_STD, 4'b0100, 4'b0011, 2'b11, {6'd2, 6'd1},
                    {16'h0202, 16'h0101}, 0, 2'd2);
`else
      vecs[7]  = mk(0, 0, 4'b1001, T_STD, D_STD, 4'b1001, 4'b1001, 2'b11, {6'd1, 6'd4},
                    {16'h0101, 16'h0404}, 1, 2'd1);
      vecs[8]  = mk(0, 0, 4'b0111, T_STD, D_STD, 4'b0100, 4'b0110, 2'b11, {6'd3, 6'd2},
                    {16'h0303, 16'h0202}, 0, 2'd3);
`endif
      vecs[9]  = mk(1, 0, 4'b0110, T_STD, D_STD, 4'b0000, 4'b0000, 2'b00, 12'h0, 32'h0, 0, 2'd0);
      vecs[10] = mk(0, 0, 4'b0011, T_STD, D_STD, 4'b0001, 4'b0011, 2'b11, {6'd2, 6'd1},
                    {16'h0202, 16'h0101}, 1, 2'd2);
`ifdef CDB_BR_PRIO_EN
      vecs[11] = mk(0, 0, 4'b1101, T_STD, D_STD, 4'b0001, 4'b0101, 2'b11, {6'd3, 6'd1},
                    {16'h0303, 16'h0101}, 1, 2'd3);
`else
      vecs[11] = mk(0, 0, 4'b1101, T_STD, D_STD, 4'b0001, 4'b1100, 2'b11, {6'd4, 6'd3},
                    {16'h0404, 16'h0303}, 0, 2'd0);
`endif

      reset         = 1'b1;
      bus.br_en     = 1'b0;
      bus.req_valid = '0;
      bus.req_t     = '0;
      bus.req_data  = '0;
      bus.req_taken = '0;
      repeat (2) @(posedge clock);

      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         drive(vecs[i]);
         #1;
         chk("req_ready", i, 64'(bus.req_ready), 64'(vecs[i].rdy));
         @(posedge clock);
         #1;
         chk("cdb_valid", i, 64'(bus.cdb_valid), 64'(vecs[i].cv));
         chk("cdb_t", i, 64'(bus.cdb_t), 64'(vecs[i].ct));
         chk("cdb_data", i, 64'(bus.cdb_data), 64'(vecs[i].cd));
         chk("cdb_taken", i, 64'(bus.cdb_taken), 64'(vecs[i].ctk));
         chk("rr_ptr", i, 64'(rr_ptr), 64'(vecs[i].rr));
      end

      // All requesters held valid: every one must be served within the wait bound
      for (int r = 0; r < NUM_REQ; r++) wait_cnt[r] = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         drive(mk(0, 0, 4'b1111, T_STD, D_STD, 4'b0000, 4'b0000, 2'b00, 12'h0, 32'h0, 0, 2'd0));
         #1;
         rdy = bus.req_ready;
         chk("grant_count", c, 64'($countones(rdy)), 64'(N));
         for (int r = 0; r < NUM_REQ; r++) begin
            if (rdy[r]) wait_cnt[r] = 0;
            else        wait_cnt[r] = wait_cnt[r] + 1;
            chk("fair_wait", c * NUM_REQ + r, 64'(wait_cnt[r] < WAIT_BOUND), 64'(1));
         end
      end

      @(negedge clock);
      bus.req_valid = '0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
